// File: rtl/serial_adder_pkg.sv
// Shared types and sizing helpers for the bit-serial adder.
// The FSM state encoding and the bit-counter width function live here.
package serial_adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_e;

  // The bit counter must reach WIDTH-1 and is never narrower than one bit
  function automatic int cnt_width(input int width);
    return (width <= 1) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/serial_adder_if.sv
// Start/done handshake and operand/result bus between a controller and serial_adder.
interface serial_adder_if #(
  parameter int WIDTH = 8
);

  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             ci;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] s;
  logic             co;

  modport master (
    output start, a, b, ci,
    input  busy, done, s, co
  );

  modport slave (
    input  start, a, b, ci,
    output busy, done, s, co
  );

endinterface

// File: rtl/serial_adder_fa_cell.sv
// One-bit full adder; the only arithmetic in the serial adder.
module fa_cell (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (a & ci) | (b & ci);

endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder: one full-adder cell plus a carry flop, LSB first, one bit per clock.
// The result is assembled in a shift register and only copied to s/co on completion.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic           clk,
  input  logic           rst,
  serial_adder_if.slave  bus
);

  localparam int             CW       = cnt_width(WIDTH);
  localparam logic [CW-1:0]  LAST_CNT = CW'(WIDTH - 1);

  state_e           state_r;
  logic [WIDTH-1:0] a_sh_r;
  logic [WIDTH-1:0] b_sh_r;
  logic [WIDTH-1:0] res_r;
  logic [WIDTH-1:0] s_r;
  logic [CW-1:0]    count_r;
  logic             carry_r;
  logic             co_r;
  logic             busy_r;
  logic             done_r;

  logic [WIDTH-1:0] res_next_s;
  logic             sum_bit_s;
  logic             carry_next_s;

  fa_cell u_fa (
    .a  (a_sh_r[0]),
    .b  (b_sh_r[0]),
    .ci (carry_r),
    .s  (sum_bit_s),
    .co (carry_next_s)
  );

  // New sum bit enters at the MSB so the LSB-first stream ends up in place
  generate
    if (WIDTH == 1) begin : g_narrow
      assign res_next_s = sum_bit_s;
    end else begin : g_wide
      assign res_next_s = {sum_bit_s, res_r[WIDTH-1:1]};
    end
  endgenerate

  // Sequencing FSM with operand shifters, carry flop and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
      a_sh_r  <= '0;
      b_sh_r  <= '0;
      res_r   <= '0;
      s_r     <= '0;
      count_r <= '0;
      carry_r <= 1'b0;
      co_r    <= 1'b0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      case (state_r)
        IDLE, DONE: begin
          done_r <= 1'b0;
          if (bus.start) begin
            a_sh_r  <= bus.a;
            b_sh_r  <= bus.b;
            carry_r <= bus.ci;
            res_r   <= '0;
            count_r <= '0;
            busy_r  <= 1'b1;
            state_r <= RUN;
          end else begin
            busy_r  <= 1'b0;
            state_r <= IDLE;
          end
        end
        RUN: begin
          a_sh_r  <= a_sh_r >> 1'b1;
          b_sh_r  <= b_sh_r >> 1'b1;
          carry_r <= carry_next_s;
          res_r   <= res_next_s;
          if (count_r == LAST_CNT) begin
            s_r     <= res_next_s;
            co_r    <= carry_next_s;
            count_r <= '0;
            busy_r  <= 1'b0;
            done_r  <= 1'b1;
            state_r <= DONE;
          end else begin
            count_r <= count_r + CW'(1);
            busy_r  <= 1'b1;
            done_r  <= 1'b0;
            state_r <= RUN;
          end
        end
        default: begin
          busy_r  <= 1'b0;
          done_r  <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end

  assign bus.busy = busy_r;
  assign bus.done = done_r;
  assign bus.s    = s_r;
  assign bus.co   = co_r;

endmodule

// File: doc/serial_adder.md
# serial_adder

Parametrised bit-serial adder: computes a + b + ci for WIDTH-bit operands using a single full-adder cell and a carry flip-flop, one bit per clock, LSB first. It replaces a WIDTH-wide combinational ripple chain where area matters more than throughput. It is the next-generation arithmetic primitive in the lab datapath library and is driven by a simple start/done handshake from a controller.

## Interface

- WIDTH, default 8, operand and sum width in bits; legal range 1..64.

- clk  input  1  rising-edge clock, sole clock domain.
- rst  input  1  synchronous, active-high reset, sampled on rising edge of clk.
- start  input  1  request a new addition; sampled only in IDLE or DONE.
- a  input  WIDTH  operand A, captured on the accepted start edge.
- b  input  WIDTH  operand B, captured on the accepted start edge.
- ci  input  1  carry in, captured on the accepted start edge.
- busy  output  1  high while bits are being processed (RUN).
- done  output  1  one-cycle pulse: s/co hold a new result.
- s  output  WIDTH  sum, (a + b + ci) mod 2^WIDTH.
- co  output  1  carry out, bit WIDTH of a + b + ci.

## Operation

- States: IDLE, RUN, DONE.
- IDLE: busy=0, done=0. start=1 -> load shift regs A<=a, B<=b, carry<=ci, count<=0, go RUN. start=0 -> stay.
- RUN: busy=1. Each edge: bit = A[0]^B[0]^carry; carry <= majority(A[0],B[0],carry); bit shifted into result reg at MSB end; A, B shift right; count++.
- When count reaches WIDTH-1 on an edge (last bit processed): s <= completed result, co <= final carry, go DONE.
- DONE: done=1, busy=0, lasts exactly one cycle. start=1 -> accepted exactly as in IDLE (back-to-back op, go RUN); start=0 -> IDLE.
- start, a, b, ci are ignored in RUN; operand changes during RUN have no effect.
- s/co are output registers, updated only on completion; stable from one done pulse until the next. Partial sums never appear on s.
- WIDTH=1: single RUN cycle; result equals a one-bit full adder.
- Reset (any state, including mid-RUN): state IDLE, busy=0, done=0, s=0, co=0, shift/count/carry regs cleared; in-flight operation discarded, no done pulse.
- rst and start in same cycle: rst wins.

## Timing

- Start accepted on edge E0 -> busy high after E0; bits processed on edges E1..E_WIDTH; s/co/done updated on edge E_WIDTH; done high for the cycle between E_WIDTH and E_WIDTH+1.
- Latency start-edge to done-visible: WIDTH edges; initiation interval WIDTH+1 cycles (start held high in DONE re-launches immediately).
- All outputs registered; no combinational path from inputs to outputs.
- Reset values: busy=0, done=0, s=0, co=0.

## Structure

- Shared package: state enum (IDLE, RUN, DONE, 2-bit encoding 00/01/10) and count width constant function ($clog2 of WIDTH, minimum 1).
- One sub-module, fa_cell: purely combinational 1-bit sum/carry (s = a^b^ci, co = majority). Instantiated once inside serial_adder; all sequencing lives in the parent.

## Test plan

- WIDTH=8, a=0x3C, b=0x21, ci=0, start pulse -> busy 8 cycles, done pulse at E8, s=0x5D, co=0.
- WIDTH=8, a=0xFF, b=0x01, ci=0 -> s=0x00, co=1; then a=0xFF, b=0xFF, ci=1 -> s=0xFF, co=1.
- start held high continuously with new operands presented at each DONE -> back-to-back results every 9 cycles, each done one cycle, s stable between pulses.
- rst asserted at E4 of an operation -> no done pulse, s=0, co=0, busy=0 next cycle; fresh start afterwards yields correct sum.
- Operands and start toggled randomly during RUN -> result reflects only values captured at E0.
- WIDTH=1 all 8 input combinations -> done at E1, s/co match full-adder truth table; WIDTH=16 random sweep vs reference model a+b+ci.
